// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//
// Purpose:
//   Shared definitions for the execute-stage ALU and the ALU decoder that
//   feeds it. The op-code enum here is the single source of truth for the
//   4-bit ALU operation encoding, so decoder and executor cannot drift apart.
//
// Contents:
//   DATA_W      default operand/result width
//   SHAMT_W     width of the shift amount taken from operand B
//   alu_op_e    4-bit ALU operation code (values 10..15 are illegal)
//   alu_state_e sequencing states of alu_seq_exec
//   is_shift()  true for the ops handled by the serial shifter
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = $clog2(DATA_W);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_AND  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_e;

    // Shift ops take the multi-cycle path through the serial shifter; every
    // other code (legal or not) finishes in a single cycle.
    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// ---------------------------------------------------------------------------
// alu_comb_core
//
// Purpose:
//   Purely combinational part of the execute ALU: ADD, SUB, SLT, SLTU, XOR,
//   OR and AND, plus detection of illegal op codes (10..15). Shift codes
//   produce a zero result here; the serial shifter in alu_seq_exec owns them.
//
// Ports:
//   i_alu_op     [3:0]        op code (alu_op_e encoding)
//   i_operand_a  [DATA_W-1:0] operand A
//   i_operand_b  [DATA_W-1:0] operand B
//   o_result     [DATA_W-1:0] single-cycle result (0 for shifts/illegal)
//   o_illegal                 high for op codes outside alu_op_e
// ---------------------------------------------------------------------------
module alu_comb_core #(
    parameter int DATA_W = alu_pkg::DATA_W
) (
    input  logic [3:0]        i_alu_op,
    input  logic [DATA_W-1:0] i_operand_a,
    input  logic [DATA_W-1:0] i_operand_b,
    output logic [DATA_W-1:0] o_result,
    output logic              o_illegal
);

    import alu_pkg::*;

    logic w_ltSigned;
    logic w_ltUnsigned;

    // Both compares are evaluated unconditionally; the op mux below picks
    // the one that matters.
    assign w_ltSigned   = $signed(i_operand_a) < $signed(i_operand_b);
    assign w_ltUnsigned = i_operand_a < i_operand_b;

    // Op mux. Every output gets a zero default so that no op code, legal
    // or not, can leave the result undriven or X.
    always_comb begin
        o_result  = '0;
        o_illegal = 1'b0;
        case (i_alu_op)
            ALU_ADD:  o_result = i_operand_a + i_operand_b;
            ALU_SUB:  o_result = i_operand_a - i_operand_b;
            ALU_SLT:  o_result = {{(DATA_W-1){1'b0}}, w_ltSigned};
            ALU_SLTU: o_result = {{(DATA_W-1){1'b0}}, w_ltUnsigned};
            ALU_XOR:  o_result = i_operand_a ^ i_operand_b;
            ALU_OR:   o_result = i_operand_a | i_operand_b;
            ALU_AND:  o_result = i_operand_a & i_operand_b;
            ALU_SLL, ALU_SRL, ALU_SRA: o_result = '0;
            default:  o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_seq_exec.sv
// ---------------------------------------------------------------------------
// alu_seq_exec
//
// Purpose:
//   Execute-stage ALU between decode/operand-select and writeback/LSU.
//   Requests and results both use a valid/ready handshake. Non-shift ops
//   (and shifts by zero) complete in one cycle; SLL/SRL/SRA walk a serial
//   shifter one bit per cycle, so a shift by n produces its result n
//   cycles after the single-cycle case.
//
// Ports:
//   i_clk        clock, rising edge
//   i_reset      asynchronous, active-high reset
//   i_valid      upstream request valid
//   o_ready      request can be accepted this cycle (combinational)
//   i_alu_op     [3:0] op code (alu_op_e)
//   i_operand_a  [DATA_W-1:0] operand A (rs1/PC)
//   i_operand_b  [DATA_W-1:0] operand B (rs2/imm); low bits are the shamt
//   o_valid      result valid
//   i_ready      downstream accepts result
//   o_alu_data   [DATA_W-1:0] registered result
//   o_illegal    op code 10..15 received, qualified by o_valid
// ---------------------------------------------------------------------------
module alu_seq_exec #(
    parameter int DATA_W = alu_pkg::DATA_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [3:0]        i_alu_op,
    input  logic [DATA_W-1:0] i_operand_a,
    input  logic [DATA_W-1:0] i_operand_b,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_alu_data,
    output logic              o_illegal
);

    import alu_pkg::*;

    // The package width is reused when the default configuration is kept,
    // otherwise it is rederived from the overriding DATA_W.
    localparam int CNT_W = (DATA_W == alu_pkg::DATA_W) ? SHAMT_W : $clog2(DATA_W);

    alu_state_e        r_state;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_shiftCnt;
    logic [3:0]        r_op;
    logic              r_valid;
    logic              r_illegal;

    logic              w_accept;
    logic              w_isShift;
    logic [CNT_W-1:0]  w_shamt;
    logic [DATA_W-1:0] w_coreResult;
    logic              w_coreIllegal;
    logic [DATA_W-1:0] w_shiftNext;

    // Single-cycle datapath works straight off the input ports so that its
    // result can be registered on the accepting edge.
    alu_comb_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .i_alu_op    (i_alu_op),
        .i_operand_a (i_operand_a),
        .i_operand_b (i_operand_b),
        .o_result    (w_coreResult),
        .o_illegal   (w_coreIllegal)
    );

    // Ready is high when idle, and also while a finished result is being
    // taken downstream this very cycle, which is what allows one result per
    // cycle for back-to-back single-cycle ops. The reset term keeps a
    // request from being seen as accepted while reset is held.
    assign o_ready   = (r_state == ST_IDLE) || ((r_state == ST_DONE) && i_ready);
    assign w_accept  = i_valid && o_ready && !i_reset;
    assign w_isShift = is_shift(i_alu_op);
    assign w_shamt   = i_operand_b[CNT_W-1:0];

    assign o_valid    = r_valid;
    assign o_alu_data = r_data;
    assign o_illegal  = r_illegal;

    // One-bit step of the serial shifter. The accumulator is r_data itself,
    // so the last step leaves the final result already in the output
    // register. SRA replicates the current MSB.
    always_comb begin
        w_shiftNext = r_data;
        case (r_op)
            ALU_SLL: w_shiftNext = {r_data[DATA_W-2:0], 1'b0};
            ALU_SRL: w_shiftNext = {1'b0, r_data[DATA_W-1:1]};
            ALU_SRA: w_shiftNext = {r_data[DATA_W-1], r_data[DATA_W-1:1]};
            default: w_shiftNext = r_data;
        endcase
    end

    // Sequencer. IDLE and DONE share the accept path so a new request taken
    // while a result drains is handled exactly like one from IDLE. A shift
    // by a non-zero amount parks in SHIFT, counting the amount down to zero;
    // everything else lands directly in DONE with its result registered.
    // Reset clears the output register as well, so an aborted shift leaves
    // no partial value visible.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_data     <= '0;
            r_shiftCnt <= '0;
            r_op       <= 4'd0;
            r_valid    <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_op <= i_alu_op;
                        if (w_isShift && (w_shamt != '0)) begin
                            r_state    <= ST_SHIFT;
                            r_data     <= i_operand_a;
                            r_shiftCnt <= w_shamt;
                            r_valid    <= 1'b0;
                            r_illegal  <= 1'b0;
                        end else begin
                            r_state    <= ST_DONE;
                            r_data     <= w_isShift ? i_operand_a : w_coreResult;
                            r_shiftCnt <= '0;
                            r_valid    <= 1'b1;
                            r_illegal  <= w_coreIllegal;
                        end
                    end else if ((r_state == ST_DONE) && i_ready) begin
                        r_state   <= ST_IDLE;
                        r_valid   <= 1'b0;
                        r_illegal <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    r_data     <= w_shiftNext;
                    r_shiftCnt <= r_shiftCnt - CNT_W'(1);
                    if (r_shiftCnt == CNT_W'(1)) begin
                        r_state <= ST_DONE;
                        r_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_exec.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_exec
//
// Purpose:
//   Directed, self-checking bench for alu_seq_exec. The driver pushes the
//   hand-computed result, illegal flag and the cycle in which the result
//   must first appear onto a queue; an independent monitor compares the
//   head of that queue whenever the DUT presents a result.
// ---------------------------------------------------------------------------
module tb_alu_seq_exec;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic        outReady;
    logic [3:0]  aluOp;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        outValid;
    logic        dnReady;
    logic [31:0] aluData;
    logic        illegal;

    typedef struct {
        logic [31:0] data;
        logic        ill;
        int          cyc;
        string       name;
    } exp_t;

    exp_t expQ[$];
    int   cyc;
    int   total;
    int   bad;
    bit   headSeen;
    int   lastWaits;
    int   busyCount;
    int   validSeen;

    alu_seq_exec #(
        .DATA_W (32)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_valid     (inValid),
        .o_ready     (outReady),
        .i_alu_op    (aluOp),
        .i_operand_a (opA),
        .i_operand_b (opB),
        .o_valid     (outValid),
        .i_ready     (dnReady),
        .o_alu_data  (aluData),
        .o_illegal   (illegal)
    );

    // Free-running clock and a cycle counter used for latency checks.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Presents one request right after a rising edge, waits (bounded) for
    // the accepting edge and pushes the expected response. lat is the
    // number of extra cycles beyond the single-cycle case.
    task automatic applyStimulus(input string name, input logic [3:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expData, input logic expIll,
                                 input int lat);
        exp_t e;
        bit   accepted;
        int   waits;
        aluOp    = op;
        opA      = a;
        opB      = b;
        inValid  = 1'b1;
        accepted = 1'b0;
        waits    = 0;
        while (!accepted && waits < 200) begin
            @(negedge clk);
            if (outReady) accepted = 1'b1;
            else waits++;
            @(posedge clk);
            #1;
        end
        inValid = 1'b0;
        lastWaits = waits;
        if (!accepted) begin
            checkOutput({name, "_accept_timeout"}, 32'd0, 32'd1);
        end else begin
            e.data = expData;
            e.ill  = expIll;
            e.cyc  = cyc + lat;
            e.name = name;
            expQ.push_back(e);
        end
    endtask

    // Counts cycles with o_ready low before the result shows up.
    task automatic countBusy();
        int guard;
        busyCount = 0;
        guard = 0;
        @(negedge clk);
        while (!outValid && guard < 100) begin
            if (!outReady) busyCount++;
            guard++;
            @(negedge clk);
        end
    endtask

    // Monitor: first appearance of a result is compared against the queue
    // head (data, flag, cycle); the entry is retired on the handshake.
    always @(negedge clk) begin
        if (outValid && !headSeen) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious_valid", 32'd1, 32'd0);
            end else begin
                checkOutput({expQ[0].name, "_data"}, aluData, expQ[0].data);
                checkOutput({expQ[0].name, "_illegal"}, {31'd0, illegal}, {31'd0, expQ[0].ill});
                checkOutput({expQ[0].name, "_cycle"}, cyc, expQ[0].cyc);
            end
            headSeen = 1'b1;
        end
        if (outValid && dnReady) begin
            if (expQ.size() != 0) void'(expQ.pop_front());
            headSeen = 1'b0;
        end
    end

    initial begin
        total    = 0;
        bad      = 0;
        headSeen = 1'b0;
        rst      = 1'b1;
        inValid  = 1'b0;
        dnReady  = 1'b1;
        aluOp    = 4'd0;
        opA      = '0;
        opB      = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_valid", {31'd0, outValid}, 32'd0);
        checkOutput("reset_data", aluData, 32'd0);
        checkOutput("reset_illegal", {31'd0, illegal}, 32'd0);
        checkOutput("reset_ready", {31'd0, outReady}, 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back single-cycle ops: each must be accepted without wait.
        applyStimulus("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 0);
        applyStimulus("sub_wrap", 4'd1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 0);
        checkOutput("b2b_sub_wait", lastWaits, 32'd0);
        applyStimulus("slt_neg", 4'd2, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 0);
        checkOutput("b2b_slt_wait", lastWaits, 32'd0);
        applyStimulus("sltu_big", 4'd3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 0);
        checkOutput("b2b_sltu_wait", lastWaits, 32'd0);
        applyStimulus("xor", 4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 0);
        applyStimulus("or", 4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 0);
        applyStimulus("and", 4'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 0);
        applyStimulus("illegal_c", 4'hC, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b1, 0);

        // Serial shifts: longest case plus a short one and shamt of zero.
        applyStimulus("sra_31", 4'd9, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0, 31);
        countBusy();
        checkOutput("sra_busy_cycles", busyCount, 32'd31);
        @(posedge clk);
        #1;
        applyStimulus("srl_31", 4'd8, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 31);
        applyStimulus("sll_4", 4'd7, 32'h0000_0001, 32'h0000_0024, 32'h0000_0010, 1'b0, 4);
        applyStimulus("sll_0", 4'd7, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1'b0, 0);

        // Backpressure: the result must hold while downstream stalls, then a
        // new request is taken on the same edge that drains it.
        @(posedge clk);
        #1;
        dnReady = 1'b0;
        applyStimulus("add_hold", 4'd0, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", {31'd0, outValid}, 32'd1);
            checkOutput("hold_data", aluData, 32'h0000_000C);
            checkOutput("hold_ready", {31'd0, outReady}, 32'd0);
        end
        @(posedge clk);
        #1;
        dnReady = 1'b1;
        applyStimulus("add_after_hold", 4'd0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 0);
        checkOutput("release_accept_wait", lastWaits, 32'd0);

        // Reset mid-shift: nothing from the aborted shift may ever appear.
        @(posedge clk);
        #1;
        applyStimulus("sll_abort", 4'd7, 32'h0000_0001, 32'h0000_0014, 32'h0010_0000, 1'b0, 20);
        repeat (10) @(posedge clk);
        #2;
        checkOutput("midshift_ready", {31'd0, outReady}, 32'd0);
        rst = 1'b1;
        expQ.delete();
        headSeen = 1'b0;
        inValid = 1'b1;
        #1;
        checkOutput("abort_valid", {31'd0, outValid}, 32'd0);
        checkOutput("abort_data", aluData, 32'd0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        inValid = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_ready", {31'd0, outReady}, 32'd1);
        validSeen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (outValid) validSeen++;
        end
        checkOutput("no_stale_result", validSeen, 32'd0);

        @(posedge clk);
        #1;
        applyStimulus("add_final", 4'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0, 0);

        // Drain the scoreboard (bounded).
        for (int i = 0; i < 100 && expQ.size() != 0; i++) @(posedge clk);
        if (expQ.size() != 0) checkOutput("drain_timeout", expQ.size(), 32'd0);
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
